shift_chain_ctrl: RTL and testbench

Sequencer for a wide chunked right-shift register chain, the datapath used in our fabric test designs.
- Fill phase: accepts DEPTH chunks over a valid/ready stream and shifts each one in at the MSB end.
- Hold phase: holds the chain full.
- Drain phase: on request, streams the chunks back out of the tail in first-in-first-out order.
- Sits between an I/O-facing stream source/sink and the chain storage; reports busy/full/done to top-level control.

---
 rtl/shift_chain_pkg.sv | 14 +
 rtl/shift_chain.sv | 30 +++
 rtl/shift_chain_ctrl.sv | 119 +++++++++++
 tb/tb_shift_chain_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_chain_pkg.sv
// rtl/shift_chain_pkg.sv - shared state encoding and default geometry for the shift chain sequencer
package shift_chain_pkg;

    localparam int CHUNK_DEF = 14;
    localparam int DEPTH_DEF = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/shift_chain.sv
// rtl/shift_chain.sv - wide chunked right-shift register, new chunks enter at the MSB end
module shift_chain
    import shift_chain_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [CHUNK-1:0] shift_in,
    output logic [CHUNK-1:0] tail
);

    localparam int W = CHUNK * DEPTH;

    logic [W-1:0] data;

    // One chunk-wide right shift per enabled cycle; the oldest chunk sits at the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {shift_in, data[W-1:CHUNK]};
        end
    end

    assign tail = data[CHUNK-1:0];

endmodule

// File: rtl/shift_chain_ctrl.sv
// rtl/shift_chain_ctrl.sv - fill/hold/drain sequencer around the shift chain storage
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_req,
    input  logic             drain_req,
    input  logic             abort,
    input  logic [CHUNK-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CHUNK-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             full,
    output logic             done,
    output logic [CW-1:0]    beat_count
);

    localparam logic [CW-1:0] LAST_BEAT  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t           state;
    logic             in_hs;
    logic             out_hs;
    logic             shift_en;
    logic [CHUNK-1:0] shift_in;

    // Abort gates both handshakes off so the abort cycle never shifts the chain
    assign in_ready  = (state == FILL)  && !abort;
    assign out_valid = (state == DRAIN) && !abort;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Fill shifts in the stream data; drain backfills with zeros so an emptied chain reads zero
    assign shift_en = in_hs || out_hs;
    assign shift_in = (state == FILL) ? in_data : '0;

    assign busy = (state == FILL) || (state == DRAIN);
    assign full = (state == FULL);

    // Phase sequencing, beat counting and the registered completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                beat_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fill_req) begin
                            state      <= FILL;
                            beat_count <= '0;
                        end
                    end
                    FILL: begin
                        if (in_hs) begin
                            if (beat_count == LAST_BEAT) begin
                                state      <= FULL;
                                beat_count <= FULL_COUNT;
                                done       <= 1'b1;
                            end else begin
                                beat_count <= beat_count + 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        // Drain wins over an overwrite fill when both are requested
                        if (drain_req) begin
                            state      <= DRAIN;
                            beat_count <= '0;
                        end else if (fill_req) begin
                            state      <= FILL;
                            beat_count <= '0;
                        end
                    end
                    DRAIN: begin
                        if (out_hs) begin
                            if (beat_count == LAST_BEAT) begin
                                state      <= IDLE;
                                beat_count <= '0;
                                done       <= 1'b1;
                            end else begin
                                beat_count <= beat_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        beat_count <= '0;
                    end
                endcase
            end
        end
    end

    shift_chain #(
        .CHUNK (CHUNK),
        .DEPTH (DEPTH)
    ) u_chain (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .shift_in (shift_in),
        .tail     (out_data)
    );

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb/tb_shift_chain_ctrl.sv - scoreboard bench for the shift chain sequencer
module tb_shift_chain_ctrl;
    import shift_chain_pkg::*;

    localparam int CHUNK = 14;
    localparam int DEPTH = 50;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             fill_req  = 1'b0;
    logic             drain_req = 1'b0;
    logic             abort     = 1'b0;
    logic [CHUNK-1:0] in_data   = '0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [CHUNK-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             full;
    logic             done;
    logic [CW-1:0]    beat_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference chain as a FIFO of chunks: index 0 is the tail, back is the newest
    logic [CHUNK-1:0] model[$];
    // Expected drained chunks, filled by stimulus and consumed by the monitor
    logic [CHUNK-1:0] exp_q[$];

    shift_chain_ctrl #(.CHUNK(CHUNK), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_req   (fill_req),
        .drain_req  (drain_req),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .full       (full),
        .done       (done),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        model.delete();
        for (int i = 0; i < DEPTH; i++) model.push_back('0);
    endtask

    task automatic model_shift(input logic [CHUNK-1:0] c);
        void'(model.pop_front());
        model.push_back(c);
    endtask

    // Monitor: every output handshake must match the next expected chunk
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("drain_unexpected_beat", 64'(out_data), 64'hdead);
            else chk("drain_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
    end

    task automatic do_fill(input bit stall);
        logic [CHUNK-1:0] d;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        chk("fill_busy", busy, 1);
        chk("fill_in_ready", in_ready, 1);
        chk("fill_count0", beat_count, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (stall && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = CHUNK'($urandom);
                tick();
                chk("fill_stall_count", beat_count, i);
                chk("fill_stall_tail", out_data, model[0]);
            end
            d        = CHUNK'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            tick();
            model_shift(d);
            if (i < DEPTH - 1) begin
                chk("fill_count", beat_count, i + 1);
                chk("fill_no_done", done, 0);
            end else begin
                chk("fill_done", done, 1);
                chk("fill_full", full, 1);
                chk("fill_count_full", beat_count, DEPTH);
                chk("full_in_ready", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("fill_done_pulse", done, 0);
        chk("hold_full", full, 1);
        chk("hold_tail", out_data, model[0]);
    endtask

    task automatic do_drain(input bit stall, input bit both);
        drain_req = 1'b1;
        fill_req  = both;
        out_ready = 1'b1;
        foreach (model[k]) exp_q.push_back(model[k]);
        tick();
        drain_req = 1'b0;
        fill_req  = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_not_full", full, 0);
        chk("drain_out_valid", out_valid, 1);
        chk("drain_count0", beat_count, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (stall && i == DEPTH / 2) begin
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("drain_stall_count", beat_count, i);
                    chk("drain_stall_data", out_data, model[0]);
                end
                out_ready = 1'b1;
            end
            fill_req = 1'($urandom_range(0, 1));
            tick();
            model_shift('0);
            if (i < DEPTH - 1) begin
                chk("drain_count", beat_count, i + 1);
                chk("drain_stays", busy, 1);
                chk("drain_in_ready", in_ready, 0);
            end else begin
                chk("drain_done", done, 1);
                chk("drain_idle_busy", busy, 0);
                chk("drain_idle_full", full, 0);
                chk("drain_idle_count", beat_count, 0);
                chk("drain_idle_valid", out_valid, 0);
            end
        end
        fill_req = 1'b0;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_chain_zero", (dut.u_chain.data == '0), 1);
        tick();
        chk("drain_done_pulse", done, 0);
        chk("drain_idle_stays", busy, 0);
    endtask

    initial begin
        logic [CHUNK-1:0] d;
        int cyc;
        int done_cyc;
        int nxt;

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", beat_count, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // drain_req in IDLE is ignored
        drain_req = 1'b1;
        out_ready = 1'b1;
        tick();
        drain_req = 1'b0;
        chk("idle_drain_busy", busy, 0);
        chk("idle_drain_valid", out_valid, 0);
        chk("idle_drain_full", full, 0);

        // Fill with in_valid toggling, overwrite fill from FULL, then drain with both requests and a stall
        do_fill(1'b1);
        do_fill(1'b0);
        do_drain(1'b1, 1'b1);

        // Abort after two beats with in_valid still high
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d        = CHUNK'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            tick();
            model_shift(d);
        end
        in_data = CHUNK'($urandom);
        abort   = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_tail_pre", out_data, model[0]);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_full", full, 0);
        chk("abort_count", beat_count, 0);
        chk("abort_no_done", done, 0);
        chk("abort_tail_held", out_data, model[0]);
        tick();
        chk("abort_no_done_late", done, 0);
        chk("abort_idle", busy, 0);

        // Reset asserted after two emitted beats of a drain
        do_fill(1'b0);
        drain_req = 1'b1;
        out_ready = 1'b1;
        foreach (model[k]) exp_q.push_back(model[k]);
        tick();
        drain_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_count", beat_count, 0);
        chk("rstmid_out_data", out_data, 0);
        exp_q.delete();
        model_clear();
        tick();
        rst_n = 1'b1;
        tick();

        // Incrementing counter fill with in_valid held high, timing the done pulse
        in_valid = 1'b1;
        in_data  = '0;
        fill_req = 1'b1;
        cyc      = 0;
        done_cyc = -1;
        nxt      = 0;
        while (cyc < 200 && done_cyc < 0) begin
            tick();
            cyc++;
            fill_req = 1'b0;
            if (cyc >= 2 && nxt < DEPTH) begin
                model_shift(CHUNK'(nxt));
                nxt++;
                in_data = CHUNK'(nxt);
            end
            if (done) done_cyc = cyc;
        end
        in_valid = 1'b0;
        chk("count_fill_done_cycle", done_cyc, DEPTH + 1);
        chk("count_fill_tail", out_data, 0);
        tick();
        do_drain(1'b0, 1'b0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
